// File: rtl/sy_ppl_fl_mp_if.sv
// sy_ppl_fl_mp_if: allocation, release and checkpoint signals of the multi-port free list
interface sy_ppl_fl_mp_if #(
  parameter int PHY_REG_NUM = 64,
  parameter int PHY_REG_WTH = $clog2(PHY_REG_NUM),
  parameter int ALLOC_PORTS = 2,
  parameter int REL_PORTS = 2,
  parameter int CKPT_NUM = 4,
  parameter int CKPT_WTH = $clog2(CKPT_NUM)
);
  logic flush_i;
  logic [ALLOC_PORTS-1:0] alloc_en_i;
  logic [ALLOC_PORTS*PHY_REG_WTH-1:0] alloc_idx_o;
  logic fl_stall_o;
  logic [REL_PORTS-1:0] rel_en_i;
  logic [REL_PORTS*PHY_REG_WTH-1:0] rel_new_phy_i;
  logic [REL_PORTS*PHY_REG_WTH-1:0] rel_old_phy_i;
  logic ckpt_take_i;
  logic [CKPT_WTH-1:0] ckpt_take_id_i;
  logic ckpt_rst_i;
  logic [CKPT_WTH-1:0] ckpt_rst_id_i;
  logic [CKPT_NUM-1:0] ckpt_free_i;
  logic [PHY_REG_WTH:0] free_cnt_o;
  logic err_o;
  modport master (
    output flush_i, alloc_en_i, rel_en_i, rel_new_phy_i, rel_old_phy_i,
    output ckpt_take_i, ckpt_take_id_i, ckpt_rst_i, ckpt_rst_id_i, ckpt_free_i,
    input alloc_idx_o, fl_stall_o, free_cnt_o, err_o
  );
  modport slave (
    input flush_i, alloc_en_i, rel_en_i, rel_new_phy_i, rel_old_phy_i,
    input ckpt_take_i, ckpt_take_id_i, ckpt_rst_i, ckpt_rst_id_i, ckpt_free_i,
    output alloc_idx_o, fl_stall_o, free_cnt_o, err_o
  );
endinterface

// File: rtl/sy_ppl_fl_mp.sv
// sy_ppl_fl_mp: multi-port physical register free list with architectural list and branch checkpoints
module sy_ppl_fl_mp #(
  parameter int PHY_REG_NUM = 64,
  parameter int PHY_REG_WTH = $clog2(PHY_REG_NUM),
  parameter int RSV_NUM = 32,
  parameter int ALLOC_PORTS = 2,
  parameter int REL_PORTS = 2,
  parameter int CKPT_NUM = 4,
  parameter int CKPT_WTH = $clog2(CKPT_NUM)
) (
  input logic clk_i,
  input logic rst_i,
  sy_ppl_fl_mp_if.slave fl
);
  typedef logic [PHY_REG_NUM-1:0] list_t;
  typedef logic [PHY_REG_WTH:0] cnt_t;
  localparam list_t RST_LIST = {{(PHY_REG_NUM-RSV_NUM){1'b1}}, {RSV_NUM{1'b0}}};
  list_t spec_q, spec_d, arch_q, arch_d, alloc_mask, rel_mask, next_spec;
  list_t slot_q [CKPT_NUM];
  list_t slot_d [CKPT_NUM];
  logic [CKPT_WTH-1:0] age_q [CKPT_NUM];
  logic [CKPT_WTH-1:0] age_d [CKPT_NUM];
  logic [CKPT_NUM-1:0] vld_q, vld_d, kill;
  logic [PHY_REG_WTH-1:0] idx [ALLOC_PORTS];
  cnt_t free_cnt_q, free_cnt_d;
  logic err_q, err_d, stall, take_en, rst_ok;
  assign stall = free_cnt_q < cnt_t'(ALLOC_PORTS);
  assign fl.fl_stall_o = stall;
  assign fl.free_cnt_o = free_cnt_q;
  assign fl.err_o = err_q;
  // port k takes the k-th lowest free bit, whether or not lower ports are enabled
  always_comb begin
    cnt_t seen;
    seen = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) idx[k] = '0;
    for (int i = 0; i < PHY_REG_NUM; i++) begin
      for (int k = 0; k < ALLOC_PORTS; k++)
        if (spec_q[i] && seen == cnt_t'(k)) idx[k] = PHY_REG_WTH'(i);
      seen = seen + cnt_t'(spec_q[i]);
    end
    for (int k = 0; k < ALLOC_PORTS; k++) fl.alloc_idx_o[k*PHY_REG_WTH +: PHY_REG_WTH] = idx[k];
  end
  always_comb begin
    logic [CKPT_WTH-1:0] dec;
    alloc_mask = '0;
    rel_mask = '0;
    arch_d = arch_q;
    err_d = err_q;
    kill = '0;
    dec = '0;
    for (int k = 0; k < ALLOC_PORTS; k++)
      if (fl.alloc_en_i[k] && !stall) alloc_mask[idx[k]] = 1'b1;
    for (int j = 0; j < REL_PORTS; j++)
      if (fl.rel_en_i[j]) begin
        rel_mask[fl.rel_old_phy_i[j*PHY_REG_WTH +: PHY_REG_WTH]] = 1'b1;
        arch_d[fl.rel_old_phy_i[j*PHY_REG_WTH +: PHY_REG_WTH]] = 1'b1;
        arch_d[fl.rel_new_phy_i[j*PHY_REG_WTH +: PHY_REG_WTH]] = 1'b0;
        err_d = err_d | spec_q[fl.rel_old_phy_i[j*PHY_REG_WTH +: PHY_REG_WTH]];
      end
    next_spec = (spec_q & ~alloc_mask) | rel_mask;
    take_en = fl.ckpt_take_i && !fl.flush_i && !fl.ckpt_rst_i;
    rst_ok = fl.ckpt_rst_i && !fl.flush_i && vld_q[fl.ckpt_rst_id_i];
    if (fl.ckpt_rst_i && !fl.flush_i && !vld_q[fl.ckpt_rst_id_i]) err_d = 1'b1;
    // any mispredict cycle drops this cycle's allocations, even when the slot is invalid
    spec_d = fl.flush_i ? arch_d : rst_ok ? slot_q[fl.ckpt_rst_id_i] | rel_mask :
             fl.ckpt_rst_i ? spec_q | rel_mask : next_spec;
    free_cnt_d = cnt_t'($countones(spec_d));
    for (int s = 0; s < CKPT_NUM; s++)
      kill[s] = vld_q[s] && (fl.ckpt_free_i[s] ||
                (rst_ok && age_q[s] <= age_q[fl.ckpt_rst_id_i]) ||
                (take_en && fl.ckpt_take_id_i == CKPT_WTH'(s)));
    // age = number of valid slots newer than this one, kept dense as slots die
    for (int s = 0; s < CKPT_NUM; s++) begin
      dec = '0;
      for (int f = 0; f < CKPT_NUM; f++)
        if (kill[f] && age_q[f] < age_q[s]) dec = dec + CKPT_WTH'(1);
      age_d[s] = age_q[s] - dec + CKPT_WTH'(take_en);
      slot_d[s] = slot_q[s] | rel_mask;
    end
    vld_d = fl.flush_i ? '0 : vld_q & ~kill;
    if (take_en) begin
      slot_d[fl.ckpt_take_id_i] = next_spec;
      vld_d[fl.ckpt_take_id_i] = 1'b1;
      age_d[fl.ckpt_take_id_i] = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_q <= RST_LIST;
      arch_q <= RST_LIST;
      vld_q <= '0;
      free_cnt_q <= cnt_t'(PHY_REG_NUM - RSV_NUM);
      err_q <= 1'b0;
      for (int s = 0; s < CKPT_NUM; s++) begin
        slot_q[s] <= '0;
        age_q[s] <= '0;
      end
    end else begin
      spec_q <= spec_d;
      arch_q <= arch_d;
      vld_q <= vld_d;
      free_cnt_q <= free_cnt_d;
      err_q <= err_d;
      for (int s = 0; s < CKPT_NUM; s++) begin
        slot_q[s] <= slot_d[s];
        age_q[s] <= age_d[s];
      end
    end
  end
endmodule

// File: doc/sy_ppl_fl_mp.md
Name: sy_ppl_fl_mp

Overview:
- Multi-port physical-register free list for the rename stage. Generalised successor of the single-port FP free list.
- Allocates up to ALLOC_PORTS destination registers per cycle and releases up to REL_PORTS registers per cycle from ROB retire.
- Keeps an architectural free list for full pipeline flush, plus CKPT_NUM branch checkpoints for selective recovery.
- One instance is used for the integer register file and one for the FP register file.

Parameters:
- PHY_REG_NUM, 64: physical registers. Must be a power of 2 and greater than RSV_NUM.
- PHY_REG_WTH, $clog2(PHY_REG_NUM): width of a physical register index.
- RSV_NUM, 32: registers 0..RSV_NUM-1 are busy at reset and hold the identity architectural mapping.
- ALLOC_PORTS, 2: allocation ports per cycle (1..4).
- REL_PORTS, 2: retire/release ports per cycle (1..4).
- CKPT_NUM, 4: checkpoint slots. CKPT_WTH = $clog2(CKPT_NUM).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  exception flush; restore from the architectural list
- alloc_en_i  in  ALLOC_PORTS  per-port allocation request
- alloc_idx_o  out  ALLOC_PORTS*PHY_REG_WTH  allocated index for each port
- fl_stall_o  out  1  fewer than ALLOC_PORTS registers free
- rel_en_i  in  REL_PORTS  retire valid
- rel_new_phy_i  in  REL_PORTS*PHY_REG_WTH  retiring instruction's new destination
- rel_old_phy_i  in  REL_PORTS*PHY_REG_WTH  previous mapping, to be freed
- ckpt_take_i  in  1  snapshot the speculative list
- ckpt_take_id_i  in  CKPT_WTH  target slot for the snapshot
- ckpt_rst_i  in  1  branch mispredict; restore a slot
- ckpt_rst_id_i  in  CKPT_WTH  slot to restore
- ckpt_free_i  in  CKPT_NUM  invalidate slots (branch resolved correctly)
- free_cnt_o  out  PHY_REG_WTH+1  number of free registers (registered)
- err_o  out  1  sticky double-free error

Behaviour:
- Reset:
  - Speculative and architectural lists: bits 0..RSV_NUM-1 = 0, remaining bits = 1.
  - All checkpoint slots invalid.
  - free_cnt_o = PHY_REG_NUM-RSV_NUM; err_o = 0; fl_stall_o = 0.
- Allocation, zero-latency combinational:
  - Port k is given the k-th lowest-index free bit of the registered speculative list.
  - Indices are always driven, even when alloc_en_i is 0.
  - fl_stall_o = (free_cnt_o < ALLOC_PORTS). The all-or-nothing rule ensures no port ever gets an invalid index.
  - When alloc_en_i[k] & ~fl_stall_o, bit alloc_idx_o[k] clears at the next edge.
  - alloc_en_i while fl_stall_o is ignored; no state change.
  - Ports that are not enabled do not consume a register. A higher port may be enabled alone and still takes the k-th lowest free bit.
- Release, effective at the next edge:
  - For each rel_en_i[j], set speculative bit rel_old_phy_i[j].
  - Architectural list: set rel_old_phy_i[j], clear rel_new_phy_i[j]. Ports are applied in order 0..REL_PORTS-1, so a later port overrides an earlier one.
  - Releasing a register whose speculative bit is already 1 sets err_o (sticky until reset); the bit stays 1.
- next_spec = (spec & ~alloc_mask) | rel_mask.
- free_cnt_o = popcount of the registered speculative list.
- Checkpoint take:
  - slot[ckpt_take_id_i] <= next_spec; the slot becomes valid.
  - Taking a valid slot overwrites it.
- Release tracking: each cycle, every valid slot (including one being written this cycle) ORs in rel_mask. Registers retired after the snapshot therefore stay free on restore.
- Checkpoint restore, when ckpt_rst_i and the slot is valid:
  - spec <= slot[id] | rel_mask. Allocations in the same cycle are discarded.
  - The restored slot and every slot taken after it (age order tracked by a per-slot age counter) are invalidated.
  - Restore of an invalid slot: no effect on the list, and err_o is set.
- ckpt_free_i[s] clears the valid bit of slot s. When ckpt_free_i and take target the same slot in one cycle, take wins.
- Priority, highest first: rst_i > flush_i > ckpt_rst_i > normal alloc/take.
  - flush_i: spec <= next_arch (the architectural list including this cycle's retires); all slots invalid; alloc and take ignored.
  - ckpt_rst_i ignores ckpt_take_i in the same cycle. Release always applies unless rst_i is asserted.
- Reset asserted mid-operation overrides every input in the same cycle.

Test Plan:
- Reset, then alloc_en_i=2'b11 -> alloc_idx_o={33,32}, fl_stall_o=0. Next cycle: free_cnt_o=30, indices {35,34}.
- Allocate until 1 free (free_cnt_o=1) -> fl_stall_o=1. alloc_en_i=2'b01 does not change free_cnt_o. One release of reg 40 -> free_cnt_o=2, stall deasserts, next allocation returns the lowest free index.
- Take ckpt 0 at free_cnt_o=32; allocate 4; retire old_phy=5; restore ckpt 0 -> free_cnt_o=33, reg 5 free, the 4 allocated regs free again.
- Take ckpts 1 then 2; restore 1 -> slot 2 invalid. Then restore 2 -> list unchanged, err_o=1.
- Retire new=32/old=3, then flush_i -> speculative list equals architectural list: 3 free, 32 busy, all slots invalid.
- Release reg 50 while already free -> err_o=1, held until rst_i.
- Same-cycle flush_i, ckpt_rst_i and alloc_en_i -> flush wins; no allocation is recorded.
